// File: rtl/lsu_sram_bridge.sv
// lsu_sram_bridge: LSU byte/half/word requests to 32-bit IS61WV25616 controller transactions.
// Optional WAIT timeout enabled by defining LSU_SRAM_TIMEOUT_EN.
module lsu_sram_bridge #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic [17:0] o_ADDR,
   output logic [31:0] o_WDATA,
   output logic [3:0]  o_BMASK,
   output logic        o_WREN,
   output logic        o_RDEN,
   input  logic [31:0] i_RDATA,
   input  logic        i_ACK
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t      state_q, state_d;
   logic        we_q, we_d, uns_q, uns_d;
   logic [1:0]  off_q, off_d, size_q, size_d;
   logic [17:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]  bmask_q, bmask_d;
   logic        wren_q, wren_d, rden_q, rden_d, rvalid_q, rvalid_d, err_q, err_d;
   logic        bad, timeout;
   logic [31:0] shifted, load_data;
`ifdef LSU_SRAM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   // Next-state, request capture, lane alignment and load extraction
   always_comb begin
      bad = (i_req_size == 2'b11) | (i_req_size == 2'b01 & i_req_addr[0]) |
            (i_req_size == 2'b10 & |i_req_addr[1:0]) | (i_req_addr[31:19] != BASE_ADDR[31:19]);
      shifted = i_RDATA >> {off_q, 3'b000};
      load_data = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                  size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : i_RDATA;
`ifdef LSU_SRAM_TIMEOUT_EN
      timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
      cnt_d   = state_q == WAIT ? cnt_q + CW'(1) : '0;
`else
      timeout = 1'b0;
`endif
      state_d  = state_q;
      we_d     = we_q;
      uns_d    = uns_q;
      off_d    = off_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      bmask_d  = bmask_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      wren_d   = 1'b0;
      rden_d   = 1'b0;
      rvalid_d = 1'b0;
      if (state_q == IDLE && i_req_valid) begin
         we_d    = i_req_we;
         uns_d   = i_req_unsigned;
         off_d   = i_req_addr[1:0];
         size_d  = i_req_size;
         addr_d  = {i_req_addr[18:2], 1'b0};
         wdata_d = i_req_size == 2'b00 ? {4{i_req_wdata[7:0]}} :
                   i_req_size == 2'b01 ? {2{i_req_wdata[15:0]}} : i_req_wdata;
         bmask_d = ~i_req_we ? 4'b1111 :
                   i_req_size == 2'b00 ? 4'b0001 << i_req_addr[1:0] :
                   i_req_size == 2'b01 ? 4'b0011 << {i_req_addr[1], 1'b0} : 4'b1111;
         state_d  = bad ? RESP : REQ;
         wren_d   = ~bad & i_req_we;
         rden_d   = ~bad & ~i_req_we;
         rvalid_d = bad;
         err_d    = bad ? 1'b1 : err_q;
         rdata_d  = bad ? 32'h0 : rdata_q;
      end else if (state_q == REQ) begin
         state_d = WAIT;
      end else if (state_q == WAIT && (i_ACK || timeout)) begin
         state_d  = RESP;
         rvalid_d = 1'b1;
         err_d    = ~i_ACK;
         rdata_d  = (~i_ACK | we_q) ? 32'h0 : load_data;
      end else if (state_q == RESP) begin
         state_d = IDLE;
      end
   end

   // State and registered outputs; reset aborts any transaction silently
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         uns_q    <= 1'b0;
         off_q    <= 2'b0;
         size_q   <= 2'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         bmask_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
         rvalid_q <= 1'b0;
`ifdef LSU_SRAM_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         uns_q    <= uns_d;
         off_q    <= off_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         bmask_q  <= bmask_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         wren_q   <= wren_d;
         rden_q   <= rden_d;
         rvalid_q <= rvalid_d;
`ifdef LSU_SRAM_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign o_req_ready  = state_q == IDLE;
   assign o_resp_valid = rvalid_q;
   assign o_resp_rdata = rdata_q;
   assign o_resp_err   = err_q;
   assign o_ADDR       = addr_q;
   assign o_WDATA      = wdata_q;
   assign o_BMASK      = bmask_q;
   assign o_WREN       = wren_q;
   assign o_RDEN       = rden_q;
endmodule

// File: tb/tb_lsu_sram_bridge.sv
// tb_lsu_sram_bridge: directed tests of lsu_sram_bridge against a small controller/SRAM model.
module tb_lsu_sram_bridge;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, resp_valid, resp_err, wren, rden;
   logic [31:0] resp_rdata, wdata, sram_rdata;
   logic [17:0] addr;
   logic [3:0]  bmask;
   logic        ack_q = 1'b0, ack_en = 1'b1, stray_ack = 1'b0;
   logic [2:0]  dly = '0;
   logic [31:0] mem [0:255];
   int          wr_tot = 0, rd_tot = 0;
   logic [17:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_bmask;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   lsu_sram_bridge dut (
      .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size), .i_req_unsigned(req_uns),
      .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
      .o_resp_err(resp_err), .o_ADDR(addr), .o_WDATA(wdata), .o_BMASK(bmask), .o_WREN(wren),
      .o_RDEN(rden), .i_RDATA(sram_rdata), .i_ACK((ack_q & ack_en) | stray_ack)
   );

   // Controller model: write ACK two cycles after the request cycle starts, read ACK five
   always @(posedge clk) begin
      ack_q <= dly == 3'd1;
      if (!rst_n) begin
         dly   <= '0;
         ack_q <= 1'b0;
      end else if (wren) begin
         dly <= 3'd1;
         for (int b = 0; b < 4; b++)
            if (bmask[b]) mem[addr[8:1]][8*b +: 8] <= wdata[8*b +: 8];
         wr_tot    <= wr_tot + 1;
         cap_addr  <= addr;
         cap_wdata <= wdata;
         cap_bmask <= bmask;
      end else if (rden) begin
         dly        <= 3'd4;
         sram_rdata <= mem[addr[8:1]];
         rd_tot     <= rd_tot + 1;
         cap_addr   <= addr;
         cap_bmask  <= bmask;
      end else if (dly != 0) begin
         dly <= dly - 3'd1;
      end
   end

   task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_uns = uns; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      lat = resp_valid ? n + 1 : -1;
      rd  = resp_rdata;
      er  = resp_err;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({req_ready, resp_valid, resp_err, wren, rden} !== 5'b10000 || resp_rdata !== 0 ||
          addr !== 0 || wdata !== 0 || bmask !== 0) begin
         bad++;
         $display("FAIL reset: ready=%b rv=%b err=%b wren=%b rden=%b rdata=%h addr=%h wdata=%h bm=%b, need 1 0 0 0 0 all-zero",
                  req_ready, resp_valid, resp_err, wren, rden, resp_rdata, addr, wdata, bmask);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_stores;
      logic [31:0] av [4] = '{32'h100, 32'h102, 32'h101, 32'h104};
      logic [1:0]  sv [4] = '{2'b10, 2'b01, 2'b00, 2'b10};
      logic [31:0] dv [4] = '{32'hDEADBEEF, 32'h0000_1234, 32'h0000_00A5, 32'h0BAD_F00D};
      logic [17:0] ea [4] = '{18'h80, 18'h80, 18'h80, 18'h82};
      logic [31:0] ew [4] = '{32'hDEADBEEF, 32'h1234_1234, 32'hA5A5_A5A5, 32'h0BAD_F00D};
      logic [3:0]  em [4] = '{4'b1111, 4'b1100, 4'b0010, 4'b1111};
      int lat, w0, r0;
      logic [31:0] rd;
      logic er;
      for (int i = 0; i < 4; i++) begin
         w0 = wr_tot; r0 = rd_tot;
         do_req(1'b1, av[i], sv[i], 1'b0, dv[i], lat, rd, er);
         total++;
         if (lat !== 4 || er !== 1'b0 || rd !== 0) begin
            bad++;
            $display("FAIL store%0d resp: lat=%0d err=%b rdata=%h, need lat=4 err=0 rdata=0", i, lat, er, rd);
         end
         total++;
         if (wr_tot - w0 !== 1 || rd_tot - r0 !== 0 || cap_addr !== ea[i] || cap_wdata !== ew[i] ||
             cap_bmask !== em[i]) begin
            bad++;
            $display("FAIL store%0d bus: wren=%0d rden=%0d addr=%h wdata=%h bm=%b, need 1 0 %h %h %b",
                     i, wr_tot - w0, rd_tot - r0, cap_addr, cap_wdata, cap_bmask, ea[i], ew[i], em[i]);
         end
      end
   endtask

   task automatic test_loads;
      logic [31:0] av [7] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100, 32'h100, 32'h101};
      logic [1:0]  sv [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
      logic        uv [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] ev [7] = '{32'h0000_0012, 32'h0000_0012, 32'h0000_1234, 32'hFFFF_A5EF,
                              32'hFFFF_FFEF, 32'h1234_A5EF, 32'h0000_00A5};
      int lat, w0, r0;
      logic [31:0] rd;
      logic er;
      for (int i = 0; i < 7; i++) begin
         w0 = wr_tot; r0 = rd_tot;
         do_req(1'b0, av[i], sv[i], uv[i], 32'hFFFF_FFFF, lat, rd, er);
         total++;
         if (lat !== 7 || er !== 1'b0 || rd !== ev[i] || wr_tot - w0 !== 0 || rd_tot - r0 !== 1 ||
             cap_bmask !== 4'b1111 || cap_addr !== 18'h80) begin
            bad++;
            $display("FAIL load%0d: lat=%0d err=%b rdata=%h wren=%0d rden=%0d bm=%b addr=%h, need 7 0 %h 0 1 1111 00080",
                     i, lat, er, rd, wr_tot - w0, rd_tot - r0, cap_bmask, cap_addr, ev[i]);
         end
      end
   endtask

   task automatic test_signext_fresh;
      int lat;
      logic [31:0] rd;
      logic er;
      do_req(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, er);
      do_req(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, lat, rd, er);
      total++;
      if (rd !== 32'hFFFF_FFDE || lat !== 7) begin
         bad++;
         $display("FAIL lb_signed: rdata=%h lat=%0d, need ffffffde 7", rd, lat);
      end
      do_req(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, lat, rd, er);
      total++;
      if (rd !== 32'h0000_00DE) begin
         bad++;
         $display("FAIL lbu: rdata=%h, need 000000de", rd);
      end
   endtask

   task automatic test_errors;
      logic        wv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] av [5] = '{32'h101, 32'h100, 32'h0008_0000, 32'h101, 32'h8000_0100};
      logic [1:0]  sv [5] = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
      int lat, w0, r0;
      logic [31:0] rd;
      logic er;
      for (int i = 0; i < 5; i++) begin
         w0 = wr_tot; r0 = rd_tot;
         do_req(wv[i], av[i], sv[i], 1'b0, 32'h5555_5555, lat, rd, er);
         repeat (6) @(posedge clk);
         #1;
         total++;
         if (lat !== 1 || er !== 1'b1 || rd !== 0 || wr_tot - w0 !== 0 || rd_tot - r0 !== 0) begin
            bad++;
            $display("FAIL err%0d: lat=%0d err=%b rdata=%h wren=%0d rden=%0d, need 1 1 0 0 0",
                     i, lat, er, rd, wr_tot - w0, rd_tot - r0);
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat, c;
      logic [31:0] rd;
      logic er;
      do_req(1'b0, 32'h101, 2'b10, 1'b0, 32'h0, lat, rd, er);
      c = 0;
      while (!req_ready && c < 10) begin
         @(posedge clk); #1; c++;
      end
      total++;
      if (c !== 1) begin
         bad++;
         $display("FAIL b2b_gap: ready after %0d cycles, need 1", c);
      end
      do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, lat, rd, er);
      total++;
      if (lat !== 7 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL b2b_load: lat=%0d err=%b rdata=%h, need 7 0 deadbeef", lat, er, rd);
      end
   endtask

   task automatic test_stray_ack;
      int seen;
      seen = 0;
      stray_ack = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         seen += resp_valid;
      end
      stray_ack = 1'b0;
      total++;
      if (seen !== 0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL stray_ack: resp pulses=%0d ready=%b, need 0 1", seen, req_ready);
      end
   endtask

   task automatic test_mid_reset;
      int seen, lat;
      logic [31:0] rd;
      logic er;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'b10; req_uns = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || rden !== 1'b0 || wren !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: ready=%b rv=%b rden=%b wren=%b, need 1 0 0 0", req_ready, resp_valid, rden, wren);
      end
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         seen += resp_valid;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL mid_reset_resp: pulses=%0d, need 0", seen);
      end
      do_req(1'b1, 32'h108, 2'b10, 1'b0, 32'hCAFE_0001, lat, rd, er);
      total++;
      if (lat !== 4 || er !== 1'b0 || cap_addr !== 18'h84 || cap_wdata !== 32'hCAFE_0001) begin
         bad++;
         $display("FAIL post_reset_sw: lat=%0d err=%b addr=%h wdata=%h, need 4 0 00084 cafe0001",
                  lat, er, cap_addr, cap_wdata);
      end
   endtask

`ifdef LSU_SRAM_TIMEOUT_EN
   task automatic test_timeout;
      int lat, seen;
      logic [31:0] rd;
      logic er;
      ack_en = 1'b0;
      do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, lat, rd, er);
      total++;
      if (lat !== 18 || er !== 1'b1 || rd !== 0) begin
         bad++;
         $display("FAIL timeout: lat=%0d err=%b rdata=%h, need 18 1 0", lat, er, rd);
      end
      ack_en = 1'b1;
      stray_ack = 1'b1;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         seen += resp_valid;
      end
      stray_ack = 1'b0;
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL timeout_stray: pulses=%0d, need 0", seen);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      sram_rdata = '0;
      test_reset;
      test_stores;
      test_loads;
      test_signext_fresh;
      test_errors;
      test_back_to_back;
      test_stray_ack;
      test_mid_reset;
`ifdef LSU_SRAM_TIMEOUT_EN
      test_timeout;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
